// File: rtl/manchester_frame_encoder.sv
// Manchester thermostat frame transmitter: {preamble, id, room, set} sent MSB first.
// Define FRAME_CRC8_EN to append a CRC-8 (poly 0x07) over the 64 payload bits.
module manchester_frame_encoder #(
  parameter int          HALF_BIT_CYCLES = 8,
  parameter logic [31:0] PREAMBLE        = 32'hAAAA_AAA5,
  parameter int          GAP_HALF_BITS   = 16,
  parameter logic        IDLE_LEVEL      = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  output logic        serial_out,
  output logic        bit_strobe,
  output logic        busy,
  output logic        done
);

`ifdef FRAME_CRC8_EN
  localparam int FRAME_BITS = 104;
`else
  localparam int FRAME_BITS = 96;
`endif
  localparam int PRESC_W = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int GAP_W   = $clog2(GAP_HALF_BITS + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(HALF_BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_HALF_BITS - 1);
  localparam logic [6:0]         BIT_LAST   = 7'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [PRESC_W-1:0]    presc;
  logic [6:0]            bit_cnt;
  logic                  second_half;
  logic [GAP_W-1:0]      gap_cnt;
  logic [63:0]           payload;
  logic [FRAME_BITS-1:0] frame_word;

  assign payload = {thermostat_id, room_temp, set_temp};

`ifdef FRAME_CRC8_EN
  // CRC is precomputed from the live field inputs so it is captured together with them.
  function automatic logic [7:0] crc8(input logic [63:0] data);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h07;
      else                  crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

  assign frame_word = {PREAMBLE, payload, crc8(payload)};
`else
  assign frame_word = {PREAMBLE, payload};
`endif

  // First half of each cell carries the inverted bit, second half the bit itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      presc       <= '0;
      bit_cnt     <= '0;
      second_half <= 1'b0;
      gap_cnt     <= '0;
      serial_out  <= IDLE_LEVEL;
      bit_strobe  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          serial_out <= IDLE_LEVEL;
          if (start) begin
            shift_reg   <= frame_word;
            serial_out  <= ~frame_word[FRAME_BITS-1];
            bit_strobe  <= 1'b1;
            busy        <= 1'b1;
            presc       <= '0;
            bit_cnt     <= '0;
            second_half <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (presc != PRESC_LAST) begin
            presc <= presc + 1'b1;
          end else begin
            presc <= '0;
            if (!second_half) begin
              second_half <= 1'b1;
              serial_out  <= shift_reg[FRAME_BITS-1];
            end else if (bit_cnt == BIT_LAST) begin
              second_half <= 1'b0;
              gap_cnt     <= '0;
              serial_out  <= IDLE_LEVEL;
              state       <= GAP;
            end else begin
              second_half <= 1'b0;
              bit_cnt     <= bit_cnt + 7'd1;
              shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
              serial_out  <= ~shift_reg[FRAME_BITS-2];
              bit_strobe  <= 1'b1;
            end
          end
        end
        GAP: begin
          serial_out <= IDLE_LEVEL;
          if (presc != PRESC_LAST) begin
            presc <= presc + 1'b1;
          end else begin
            presc <= '0;
            if (gap_cnt == GAP_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
